// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 4-bit ALU: accepts one request, holds ALU inputs
// for SETTLE cycles, captures the selected result group and returns it.
module alu_cmd_sequencer #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_chain,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [4:0] alu_y_add,
  input  logic [4:0] alu_y_sub,
  input  logic [3:0] alu_y_and,
  input  logic       alu_eq,
  input  logic       alu_gt,
  input  logic       alu_lt,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [4:0] rsp_data,
  output logic [2:0] rsp_flags,
  output logic [1:0] rsp_op
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [3:0] last_result;
  logic       accept, capture;
  logic [4:0] cap_data;
  logic [2:0] cap_flags;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = EXEC;
      end
      EXEC: begin
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept  = (state == IDLE) && cmd_valid;
  assign capture = (state == EXEC) && (cnt == 4'd0);

  // The ALU gates unselected groups to zero; pick the one the held select enabled.
  always_comb begin
    cap_data  = '0;
    cap_flags = '0;
    case (alu_sel)
      2'b00: cap_data  = alu_y_add;
      2'b01: cap_data  = alu_y_sub;
      2'b10: cap_flags = {alu_eq, alu_gt, alu_lt};
      2'b11: cap_data  = {1'b0, alu_y_and};
      default: cap_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      cnt         <= '0;
      last_result <= '0;
      rsp_data    <= '0;
      rsp_flags   <= '0;
      rsp_op      <= '0;
    end else if (accept) begin
      alu_a   <= cmd_chain ? last_result : cmd_a;
      alu_b   <= cmd_b;
      alu_sel <= cmd_op;
      cnt     <= CNT_INIT;
    end else if (capture) begin
      rsp_data    <= cap_data;
      rsp_flags   <= cap_flags;
      rsp_op      <= alu_sel;
      last_result <= cap_data[3:0];
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
    end else if (state == EXEC) begin
      cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU plus an arithmetic reference
// model of each command's response, directed cases then random traffic.
module tb_alu_cmd_sequencer;

  localparam int SETTLE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic       cmd_chain = 1'b0;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_sel;
  logic [4:0] alu_y_add, alu_y_sub;
  logic [3:0] alu_y_and;
  logic       alu_eq, alu_gt, alu_lt;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [4:0] rsp_data;
  logic [2:0] rsp_flags;
  logic [1:0] rsp_op;

  int         tests = 0;
  int         fails = 0;
  logic [3:0] last_res = '0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_y_add(alu_y_add), .alu_y_sub(alu_y_sub), .alu_y_and(alu_y_and),
    .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_lt(alu_lt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_op(rsp_op)
  );

  // Combinational ALU with per-group gating
  always_comb begin
    alu_y_add = '0;
    alu_y_sub = '0;
    alu_y_and = '0;
    alu_eq    = 1'b0;
    alu_gt    = 1'b0;
    alu_lt    = 1'b0;
    case (alu_sel)
      2'b00: alu_y_add = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: alu_y_sub = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
      2'b10: begin
        alu_eq = (alu_a == alu_b);
        alu_gt = (alu_a > alu_b);
        alu_lt = (alu_a < alu_b);
      end
      default: alu_y_and = alu_a & alu_b;
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    cmd_op    = 2'($urandom);
    cmd_a     = 4'($urandom);
    cmd_b     = 4'($urandom);
    cmd_chain = 1'($urandom);
  endtask

  // Issue one command, check timing and response, hold rsp_ready low for stall cycles.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic chain, input int stall);
    logic [3:0] ea;
    logic [4:0] ed;
    logic [2:0] ef;
    int ia, ib;
    ea = chain ? last_res : a;
    ia = int'(ea);
    ib = int'(b);
    ef = 3'b000;
    case (op)
      2'b00:   ed = 5'(ia + ib);
      2'b01:   ed = (ia >= ib ? 5'd16 : 5'd0) + 5'((ia - ib) & 15);
      2'b10: begin
        ed = 5'd0;
        ef = {ia == ib, ia > ib, ia < ib};
      end
      default: ed = 5'(ia & ib);
    endcase

    @(negedge clk);
    chk("idle_cmd_ready", 8'(cmd_ready), 8'd1);
    chk("idle_rsp_valid", 8'(rsp_valid), 8'd0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_chain = chain;
    rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    scramble();
    for (int k = 0; k < SETTLE; k++) begin
      chk("exec_alu_a", 8'(alu_a), 8'(ea));
      chk("exec_alu_b", 8'(alu_b), 8'(b));
      chk("exec_alu_sel", 8'(alu_sel), 8'(op));
      chk("exec_cmd_ready", 8'(cmd_ready), 8'd0);
      chk("exec_rsp_valid", 8'(rsp_valid), 8'd0);
      @(negedge clk);
      scramble();
    end
    last_res = ed[3:0];
    chk("rsp_valid", 8'(rsp_valid), 8'd1);
    chk("rsp_data", 8'(rsp_data), 8'(ed));
    chk("rsp_flags", 8'(rsp_flags), 8'(ef));
    chk("rsp_op", 8'(rsp_op), 8'(op));
    chk("rsp_alu_a", 8'(alu_a), 8'd0);
    chk("rsp_alu_sel", 8'(alu_sel), 8'd0);
    chk("rsp_cmd_ready", 8'(cmd_ready), 8'd0);
    for (int s = 0; s < stall; s++) begin
      cmd_valid = 1'b1;
      scramble();
      @(negedge clk);
      chk("stall_rsp_valid", 8'(rsp_valid), 8'd1);
      chk("stall_rsp_data", 8'(rsp_data), 8'(ed));
      chk("stall_rsp_flags", 8'(rsp_flags), 8'(ef));
      chk("stall_rsp_op", 8'(rsp_op), 8'(op));
      chk("stall_cmd_ready", 8'(cmd_ready), 8'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rsp_valid", 8'(rsp_valid), 8'd0);
    chk("post_cmd_ready", 8'(cmd_ready), 8'd1);
    chk("post_alu_a", 8'(alu_a), 8'd0);
    chk("post_alu_sel", 8'(alu_sel), 8'd0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_cmd_ready", 8'(cmd_ready), 8'd1);
    chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
    chk("rst_alu_a", 8'(alu_a), 8'd0);
    chk("rst_alu_b", 8'(alu_b), 8'd0);
    chk("rst_alu_sel", 8'(alu_sel), 8'd0);
    chk("rst_rsp_data", 8'(rsp_data), 8'd0);
    chk("rst_rsp_flags", 8'(rsp_flags), 8'd0);
    chk("rst_rsp_op", 8'(rsp_op), 8'd0);
  endtask

  initial begin
    // Reset with a command pending: it must not be taken
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_a     = 4'd5;
    cmd_b     = 4'd6;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_state();
    cmd_valid = 1'b0;

    run_cmd(2'b00, 4'd9, 4'd8, 1'b0, 0);
    run_cmd(2'b01, 4'd3, 4'd5, 1'b0, 0);
    run_cmd(2'b01, 4'd5, 4'd3, 1'b0, 0);
    run_cmd(2'b01, 4'd0, 4'd0, 1'b0, 0);
    run_cmd(2'b10, 4'd6, 4'd6, 1'b0, 0);
    run_cmd(2'b10, 4'd2, 4'd7, 1'b0, 0);
    run_cmd(2'b10, 4'd15, 4'd0, 1'b0, 0);

    run_cmd(2'b00, 4'd4, 4'd5, 1'b0, 0);
    run_cmd(2'b11, 4'd0, 4'd12, 1'b1, 0);
    run_cmd(2'b10, 4'd0, 4'd8, 1'b1, 0);

    run_cmd(2'b00, 4'd15, 4'd15, 1'b0, 5);

    for (int i = 0; i < 40; i++)
      run_cmd(2'($urandom), 4'($urandom), 4'($urandom),
              ($urandom_range(0, 2) == 0), int'($urandom_range(0, 2)));

    // Reset in the second EXEC cycle of a command
    run_cmd(2'b00, 4'd1, 4'd1, 1'b0, 0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_a     = 4'd7;
    cmd_b     = 4'd7;
    cmd_chain = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("midexec_alu_a", 8'(alu_a), 8'd7);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_res = 4'd0;
    chk_reset_state();
    repeat (SETTLE + 1) begin
      @(negedge clk);
      chk("after_rst_no_rsp", 8'(rsp_valid), 8'd0);
    end
    run_cmd(2'b00, 4'd7, 4'd3, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side controller that drives the four-bit ALU. It accepts operation requests over a valid/ready interface and presents operands and select to the ALU for a programmable settle time. It then captures the single result the select enabled and returns it over a second valid/ready interface. It sits between a command source (test sequencer or datapath controller) and the combinational ALU, converting the ALU's four gated result groups into one response word.

## Interface
- SETTLE, 1: cycles operands/select are held at the ALU before capture; legal 1..15; 0 illegal.

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept command
- cmd_op  input  2  00 add, 01 sub, 10 compare, 11 and (ALU Sel encoding)
- cmd_a  input  4  operand A
- cmd_b  input  4  operand B
- cmd_chain  input  1  1: use last result low nibble as A instead of cmd_a
- alu_a  output  4  operand A to ALU
- alu_b  output  4  operand B to ALU
- alu_sel  output  2  select to ALU
- alu_y_add  input  5  ALU add result (zero when not selected)
- alu_y_sub  input  5  ALU sub result, A + ~B + 1
- alu_y_and  input  4  ALU and result
- alu_eq, alu_gt, alu_lt  input  1 each  ALU compare flags
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  5  result word
- rsp_flags  output  3  {eq, gt, lt}; 000 for non-compare ops
- rsp_op  output  2  opcode of this response

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: cmd_ready=1; alu_a=alu_b=0, alu_sel=00. On cmd_valid&&cmd_ready: register op, A (cmd_a, or last_result[3:0] if cmd_chain), B into alu_a/alu_b/alu_sel; load settle counter with SETTLE-1; go EXEC.
- EXEC: cmd_ready=0; ALU inputs held stable. Counter decrements each cycle; at the edge where counter==0, capture and go RESP.
- Capture mux by registered op: 00 -> rsp_data=alu_y_add; 01 -> alu_y_sub; 11 -> {1'b0, alu_y_and}; 10 -> rsp_data=0, rsp_flags={alu_eq,alu_gt,alu_lt}. Non-compare: rsp_flags=000.
- Sub: bit 4 is carry-out (1 = no borrow, A>=B); low 4 bits are A-B mod 16. No sign interpretation.
- On capture, last_result <= rsp_data value captured (compare stores 0).
- RESP: rsp_valid=1; rsp_data/flags/op stable until handshake; alu_a/alu_b/alu_sel return to 0. On rsp_valid&&rsp_ready go IDLE.
- cmd_ready is never asserted while rsp_valid is high; at most one command in flight.
- cmd_* inputs are ignored outside the acceptance edge; changes during EXEC have no effect.

## Timing
- Reset (any state, including mid-EXEC/RESP): state IDLE, cmd_ready=1 in first cycle after reset edge, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_op=0, alu_a=alu_b=0, alu_sel=00, last_result=0, counter=0. In-flight command discarded, no response.
- Accept at edge E0 -> ALU inputs valid from E0; capture at edge E0+SETTLE; rsp_valid high from E0+SETTLE.
- rsp_ready held high: handshake at E0+SETTLE+1; cmd_ready high from that edge; next accept earliest E0+SETTLE+2. Peak throughput one command per SETTLE+2 cycles.
- rsp_ready low: RESP held indefinitely, outputs bit-stable.
- cmd_valid high during reset edge: not accepted.

## Test plan
- Reset: rst high 2 cycles mid-stream -> next cycle cmd_ready=1, rsp_valid=0, alu_a/alu_b/alu_sel=0, rsp_data=0.
- ADD A=9 B=8, SETTLE=1, rsp_ready=1 -> accept at E0, rsp_valid at E1 only, rsp_data=5'b10001, flags 000, rsp_op=00; cmd_ready back at E2.
- SUB A=3 B=5 -> rsp_data=5'b01110; SUB A=5 B=3 -> 5'b10010; SUB A=0 B=0 -> 5'b10000.
- CMP A=6 B=6 -> data 0, flags 100; A=2 B=7 -> 001; A=15 B=0 -> 010.
- Chain: ADD 4+5 -> 01001; then AND cmd_chain=1 cmd_a=0 B=12 -> alu_a=9, rsp_data=01000; then CMP chained B=8 -> flags 100.
- Backpressure/SETTLE=3: rsp_ready low 5 cycles -> rsp_* stable, cmd_ready=0, held cmd_valid not accepted; rst asserted at second EXEC cycle of a new command -> no rsp_valid, last_result=0.
